// File: rtl/instr_seq_ctrl_if.sv
// Control bundle between the instruction sequencer (master) and its datapath, code FIFO and
// decrypt-return path (slave).
interface instr_seq_ctrl_if #(
  parameter int OP_W      = 6,
  parameter int FUNC_W    = 6,
  parameter int NUM_RD_CH = 2
);
  localparam int CH_W = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;

  logic                 code_fifo_empty;
  logic                 code_fifo_rd_rst_busy;
  logic [OP_W-1:0]      op_bits;
  logic [FUNC_W-1:0]    func_from_ir;
  logic                 psr_z;
  logic [NUM_RD_CH-1:0] decrypt_done;

  logic                 code_fifo_rd_en;
  logic                 ir_latch;
  logic                 alu_src_latch;
  logic                 alu_out_latch;
  logic                 alu_src2_sel;
  logic [1:0]           reg_inp_src_sel;
  logic                 register_write;
  logic                 mwr_en;
  logic                 mrr_en;
  logic                 wb_sel;
  logic [CH_W-1:0]      wb_ch;
  logic [NUM_RD_CH-1:0] wb_ack;
  logic                 pc_load;
  logic [1:0]           pc_src_sel;
  logic [FUNC_W-1:0]    func;
  logic                 busy;
  logic                 flush_err;

  modport master (
    input  code_fifo_empty, code_fifo_rd_rst_busy, op_bits, func_from_ir, psr_z, decrypt_done,
    output code_fifo_rd_en, ir_latch, alu_src_latch, alu_out_latch, alu_src2_sel,
           reg_inp_src_sel, register_write, mwr_en, mrr_en, wb_sel, wb_ch, wb_ack,
           pc_load, pc_src_sel, func, busy, flush_err
  );

  modport slave (
    output code_fifo_empty, code_fifo_rd_rst_busy, op_bits, func_from_ir, psr_z, decrypt_done,
    input  code_fifo_rd_en, ir_latch, alu_src_latch, alu_out_latch, alu_src2_sel,
           reg_inp_src_sel, register_write, mwr_en, mrr_en, wb_sel, wb_ch, wb_ack,
           pc_load, pc_src_sel, func, busy, flush_err
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer with round-robin decrypt writeback and PC-load flush handshake.
// Define INSTR_SEQ_FLUSH_TIMEOUT_EN to bound the flush-start wait by FLUSH_TO cycles (sets flush_err).
module instr_seq_ctrl #(
  parameter int OP_W      = 6,
  parameter int FUNC_W    = 6,
  parameter int ALU_LAT   = 2,
  parameter int NUM_RD_CH = 2,
  parameter int FLUSH_TO  = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_seq_ctrl_if.master bus
);
  localparam int CH_W    = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;
  localparam int CNT_MAX = (ALU_LAT > FLUSH_TO) ? ALU_LAT : FLUSH_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPERAND, S_EXEC, S_WRITE, S_FLUSH_ARM, S_FLUSH_WAIT, S_RD_WB
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CH_W-1:0]      r_rr_ptr;
  logic                 r_busy_seen;
  logic                 r_code_fifo_rd_en;
  logic                 r_ir_latch;
  logic                 r_alu_src_latch;
  logic                 r_alu_out_latch;
  logic                 r_register_write;
  logic                 r_mwr_en;
  logic                 r_mrr_en;
  logic                 r_wb_sel;
  logic [CH_W-1:0]      r_wb_ch;
  logic [NUM_RD_CH-1:0] r_wb_ack;
  logic                 r_pc_load;
  logic [1:0]           r_pc_src_sel;

  logic [1:0] w_class;
  logic [3:0] w_sub;
  logic       w_is_store, w_is_load, w_is_jump, w_is_branch, w_reg_wr;
  logic [1:0] w_rsel;

  assign w_class     = bus.op_bits[OP_W-1 -: 2];
  assign w_sub       = bus.op_bits[3:0];
  assign w_is_store  = (w_class == 2'b01) && (w_sub == 4'b1111);
  assign w_is_load   = (w_class == 2'b01) && (w_sub == 4'b1110);
  assign w_is_jump   = (w_class == 2'b10);
  assign w_is_branch = (w_class == 2'b11) &&
                       (((w_sub == 4'b0001) && bus.psr_z) || ((w_sub == 4'b1010) && !bus.psr_z));
  assign w_reg_wr    = (w_class == 2'b00) || ((w_class == 2'b01) && !w_is_store && !w_is_load);

  // Round-robin: prefer requests at or above the pointer, else wrap to the lowest request.
  logic [NUM_RD_CH-1:0] w_hi_mask, w_req_hi, w_req_sel, w_first_oh;
  logic [CH_W-1:0]      w_enc [NUM_RD_CH+1];
  logic [CH_W-1:0]      w_grant;

  generate
    for (genvar gi = 0; gi < NUM_RD_CH; gi++) begin : g_rr
      assign w_hi_mask[gi] = (CH_W'(gi) >= r_rr_ptr);
      assign w_enc[gi+1]   = w_enc[gi] | (w_first_oh[gi] ? CH_W'(gi) : '0);
    end
  endgenerate

  assign w_enc[0]   = '0;
  assign w_req_hi   = bus.decrypt_done & w_hi_mask;
  assign w_req_sel  = (|w_req_hi) ? w_req_hi : bus.decrypt_done;
  assign w_first_oh = w_req_sel & (~w_req_sel + NUM_RD_CH'(1));
  assign w_grant    = w_enc[NUM_RD_CH];

  always_comb begin
    w_rsel = 2'd2;
    if (r_state == S_RD_WB)
      w_rsel = 2'd3;
    else if ((w_class == 2'b01) && ((w_sub == 4'b1100) || (w_sub == 4'b1101)))
      w_rsel = 2'd0;
    else if ((w_class == 2'b00) && (w_sub == 4'b1100))
      w_rsel = 2'd1;
  end

`ifdef INSTR_SEQ_FLUSH_TIMEOUT_EN
  logic r_flush_err;
  assign bus.flush_err = r_flush_err;
`else
  assign bus.flush_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_rr_ptr          <= '0;
      r_busy_seen       <= 1'b0;
      r_code_fifo_rd_en <= 1'b0;
      r_ir_latch        <= 1'b0;
      r_alu_src_latch   <= 1'b0;
      r_alu_out_latch   <= 1'b0;
      r_register_write  <= 1'b0;
      r_mwr_en          <= 1'b0;
      r_mrr_en          <= 1'b0;
      r_wb_sel          <= 1'b0;
      r_wb_ch           <= '0;
      r_wb_ack          <= '0;
      r_pc_load         <= 1'b0;
      r_pc_src_sel      <= 2'b00;
`ifdef INSTR_SEQ_FLUSH_TIMEOUT_EN
      r_flush_err       <= 1'b0;
`endif
    end else begin
      // Outputs are pulses belonging to the state being entered.
      r_code_fifo_rd_en <= 1'b0;
      r_ir_latch        <= 1'b0;
      r_alu_src_latch   <= 1'b0;
      r_alu_out_latch   <= 1'b0;
      r_register_write  <= 1'b0;
      r_mwr_en          <= 1'b0;
      r_mrr_en          <= 1'b0;
      r_wb_sel          <= 1'b0;
      r_wb_ch           <= '0;
      r_wb_ack          <= '0;
      r_pc_load         <= 1'b0;
      r_pc_src_sel      <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|bus.decrypt_done) begin
            r_state          <= S_RD_WB;
            r_wb_sel         <= 1'b1;
            r_wb_ch          <= w_grant;
            r_wb_ack         <= w_first_oh;
            r_register_write <= 1'b1;
          end else if (!bus.code_fifo_empty) begin
            r_state           <= S_FETCH;
            r_code_fifo_rd_en <= 1'b1;
            r_ir_latch        <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state         <= S_OPERAND;
          r_alu_src_latch <= 1'b1;
        end
        S_OPERAND: begin
          r_state         <= S_EXEC;
          r_alu_out_latch <= 1'b1;
          r_cnt           <= CNT_W'(ALU_LAT - 1);
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_state          <= S_WRITE;
            r_register_write <= w_reg_wr;
            r_mwr_en         <= w_is_store;
            r_mrr_en         <= w_is_load;
            r_pc_load        <= w_is_jump || w_is_branch;
            r_pc_src_sel     <= w_is_jump ? 2'b01 : (w_is_branch ? 2'b10 : 2'b00);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (r_pc_load) begin
            r_state     <= S_FLUSH_ARM;
            r_cnt       <= '0;
            r_busy_seen <= bus.code_fifo_rd_rst_busy;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH_ARM: begin
          if (bus.code_fifo_rd_rst_busy || r_busy_seen) begin
            r_state     <= S_FLUSH_WAIT;
            r_busy_seen <= 1'b0;
          end
`ifdef INSTR_SEQ_FLUSH_TIMEOUT_EN
          else if (r_cnt == CNT_W'(FLUSH_TO - 1)) begin
            r_state     <= S_IDLE;
            r_flush_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_FLUSH_WAIT: begin
          if (!bus.code_fifo_rd_rst_busy)
            r_state <= S_IDLE;
        end
        S_RD_WB: begin
          r_state  <= S_IDLE;
          r_rr_ptr <= (r_wb_ch == CH_W'(NUM_RD_CH - 1)) ? '0 : r_wb_ch + CH_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.code_fifo_rd_en = r_code_fifo_rd_en;
  assign bus.ir_latch        = r_ir_latch;
  assign bus.alu_src_latch   = r_alu_src_latch;
  assign bus.alu_out_latch   = r_alu_out_latch;
  assign bus.register_write  = r_register_write;
  assign bus.mwr_en          = r_mwr_en;
  assign bus.mrr_en          = r_mrr_en;
  assign bus.wb_sel          = r_wb_sel;
  assign bus.wb_ch           = r_wb_ch;
  assign bus.wb_ack          = r_wb_ack;
  assign bus.pc_load         = r_pc_load;
  assign bus.pc_src_sel      = r_pc_src_sel;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.alu_src2_sel    = (w_class == 2'b01);
  assign bus.reg_inp_src_sel = w_rsel;
  assign bus.func            = (w_class == 2'b00) ? bus.func_from_ir : '0;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Randomized bench for instr_seq_ctrl: per-instruction pulse timelines and round-robin writeback
// are predicted from the instruction rules; INSTR_SEQ_FLUSH_TIMEOUT_EN adds the timeout scenario.
module tb_instr_seq_ctrl;
  localparam int OP_W      = 6;
  localparam int FUNC_W    = 6;
  localparam int ALU_LAT   = 2;
  localparam int NUM_RD_CH = 2;
  localparam int FLUSH_TO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  int   rr_ptr = 0;

  always #5 clk = ~clk;

  instr_seq_ctrl_if #(.OP_W(OP_W), .FUNC_W(FUNC_W), .NUM_RD_CH(NUM_RD_CH)) bus ();

  instr_seq_ctrl #(
    .OP_W(OP_W), .FUNC_W(FUNC_W), .ALU_LAT(ALU_LAT), .NUM_RD_CH(NUM_RD_CH), .FLUSH_TO(FLUSH_TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] reg_outs();
    return 64'({bus.code_fifo_rd_en, bus.ir_latch, bus.alu_src_latch, bus.alu_out_latch,
                bus.register_write, bus.mwr_en, bus.mrr_en, bus.wb_sel, bus.wb_ch, bus.wb_ack,
                bus.pc_load, bus.pc_src_sel, bus.busy, bus.flush_err});
  endfunction

  // Channel nearest to the pointer going upward (modulo NUM_RD_CH) wins.
  function automatic int rr_pick(input logic [NUM_RD_CH-1:0] req, input int ptr);
    int best = -1;
    int best_d = NUM_RD_CH;
    logic [NUM_RD_CH-1:0] sh;
    for (int c = 0; c < NUM_RD_CH; c++) begin
      sh = req >> c;
      if (sh[0] && ((c - ptr + NUM_RD_CH) % NUM_RD_CH) < best_d) begin
        best   = c;
        best_d = (c - ptr + NUM_RD_CH) % NUM_RD_CH;
      end
    end
    return best;
  endfunction

  // Runs one instruction from IDLE. d = cycles after WRITE until flush busy rises (<0: never),
  // h = cycles it stays high, raise_ch >= 0 raises that decrypt request mid-instruction.
  task automatic run_instr(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn, input logic z,
                           input int d, input int h, input int raise_ch);
    logic [1:0]  cls;
    logic [3:0]  sub;
    logic        e_rw, e_mwr, e_mrr, taken;
    logic [1:0]  e_pcs, got_pcs, e_rsel;
    logic [63:0] m_rd, m_ir, m_src, m_out, m_rw, m_mwr, m_mrr, m_pcl;
    int          w, e_r, r;
    cls   = op[OP_W-1 -: 2];
    sub   = op[3:0];
    e_mwr = (cls == 2'b01) && (sub == 4'hF);
    e_mrr = (cls == 2'b01) && (sub == 4'hE);
    e_rw  = (cls == 2'b00) || ((cls == 2'b01) && !e_mwr && !e_mrr);
    taken = (cls == 2'b10) || ((cls == 2'b11) && (((sub == 4'h1) && z) || ((sub == 4'hA) && !z)));
    e_pcs = !taken ? 2'b00 : ((cls == 2'b10) ? 2'b01 : 2'b10);
    if ((cls == 2'b01) && ((sub == 4'hC) || (sub == 4'hD))) e_rsel = 2'd0;
    else if ((cls == 2'b00) && (sub == 4'hC))                e_rsel = 2'd1;
    else                                                      e_rsel = 2'd2;
    w = 3 + ALU_LAT;
    if (!taken)      e_r = w + 1;
    else if (d < 0)  e_r = w + FLUSH_TO + 1;
    else if (d == 0) e_r = w + h + 1;
    else             e_r = w + d + h + 1;

    bus.op_bits = op;
    bus.func_from_ir = fn;
    bus.psr_z = z;
    bus.code_fifo_rd_rst_busy = 1'b0;
    bus.code_fifo_empty = 1'b0;
    {m_rd, m_ir, m_src, m_out, m_rw, m_mwr, m_mrr, m_pcl} = '0;
    got_pcs = 2'b00;
    r = -1;
    for (int cyc = 1; cyc <= 60 && r < 0; cyc++) begin
      @(posedge clk);
      #1;
      bus.code_fifo_empty = 1'b1;
      bus.code_fifo_rd_rst_busy = taken && (d >= 0) && (cyc >= w + d) && (cyc < w + d + h);
      if (cyc == 2 && raise_ch >= 0)
        bus.decrypt_done = bus.decrypt_done | (NUM_RD_CH'(1) << raise_ch);
      @(negedge clk);
      m_rd  |= 64'(bus.code_fifo_rd_en) << cyc;
      m_ir  |= 64'(bus.ir_latch) << cyc;
      m_src |= 64'(bus.alu_src_latch) << cyc;
      m_out |= 64'(bus.alu_out_latch) << cyc;
      m_rw  |= 64'(bus.register_write) << cyc;
      m_mwr |= 64'(bus.mwr_en) << cyc;
      m_mrr |= 64'(bus.mrr_en) << cyc;
      m_pcl |= 64'(bus.pc_load) << cyc;
      if (bus.pc_load) got_pcs = bus.pc_src_sel;
      if (cyc == 1) begin
        chk("rsel", 64'(bus.reg_inp_src_sel), 64'(e_rsel));
        chk("src2_sel", 64'(bus.alu_src2_sel), 64'(cls == 2'b01));
        chk("func", 64'(bus.func), (cls == 2'b00) ? 64'(fn) : 64'(0));
      end
      if (!bus.busy) r = cyc;
    end
    chk("ret_cycle", 64'(r), 64'(e_r));
    chk("rd_en", m_rd, 64'(1) << 1);
    chk("ir_latch", m_ir, 64'(1) << 1);
    chk("src_latch", m_src, 64'(1) << 2);
    chk("out_latch", m_out, 64'(1) << 3);
    chk("reg_write", m_rw, 64'(e_rw) << w);
    chk("mwr_en", m_mwr, 64'(e_mwr) << w);
    chk("mrr_en", m_mrr, 64'(e_mrr) << w);
    chk("pc_load", m_pcl, 64'(taken) << w);
    chk("pc_src_sel", 64'(got_pcs), 64'(e_pcs));
    chk("flush_err", 64'(bus.flush_err), 64'(d < 0 && taken));
    $display("instr op=%b func=%h z=%0d d=%0d h=%0d ret_cycle=%0d", op, fn, z, d, h, r);
  endtask

  // Serves all pending decrypt requests; the producer drops a request on its wb_ack.
  task automatic drain(input logic keep_fifo);
    int n_exp, n_got, g;
    n_exp = $countones(bus.decrypt_done);
    n_got = 0;
    bus.code_fifo_empty = !keep_fifo;
    for (int cyc = 0; cyc < 8 * NUM_RD_CH + 8 && bus.decrypt_done != '0; cyc++) begin
      @(negedge clk);
      chk("wb_no_fetch", 64'(bus.code_fifo_rd_en), 64'(0));
      if (bus.wb_sel) begin
        g = rr_pick(bus.decrypt_done, rr_ptr);
        chk("wb_ch", 64'(bus.wb_ch), 64'(g));
        chk("wb_ack", 64'(bus.wb_ack), 64'(1) << g);
        chk("wb_reg_write", 64'(bus.register_write), 64'(1));
        chk("wb_rsel", 64'(bus.reg_inp_src_sel), 64'(3));
        $display("wb grant ch=%0d pending=%b", bus.wb_ch, bus.decrypt_done);
        rr_ptr = (g + 1) % NUM_RD_CH;
        n_got++;
        bus.decrypt_done = bus.decrypt_done & ~bus.wb_ack;
        if (bus.decrypt_done == '0) bus.code_fifo_empty = 1'b1;
      end
    end
    chk("wb_count", 64'(n_got), 64'(n_exp));
    @(negedge clk);
    chk("wb_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic reset_mid_exec();
    bus.op_bits = '0;
    bus.code_fifo_empty = 1'b0;
    @(posedge clk);
    #1 bus.code_fifo_empty = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_exec", 64'({bus.busy, bus.alu_out_latch}), 64'(3));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rr_ptr = 0;
    @(negedge clk);
    chk("reset_in_exec", reg_outs(), 64'(0));
    $display("reset during EXEC");
  endtask

  initial begin
    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] fn;
    int                d, h, rc;
    bus.code_fifo_empty = 1'b1;
    bus.code_fifo_rd_rst_busy = 1'b0;
    bus.op_bits = '0;
    bus.func_from_ir = '0;
    bus.psr_z = 1'b0;
    bus.decrypt_done = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", reg_outs(), 64'(0));

    run_instr(6'b000000, 6'h21, 1'b0, 0, 2, -1);
    run_instr(6'b011111, 6'h05, 1'b0, 0, 2, -1);
    run_instr(6'b011110, 6'h05, 1'b0, 0, 2, -1);
    run_instr(6'b110001, 6'h00, 1'b1, 3, 4, -1);
    run_instr(6'b110001, 6'h00, 1'b0, 3, 4, -1);
    run_instr(6'b001100, 6'h3A, 1'b0, 0, 2, -1);
    run_instr(6'b011101, 6'h11, 1'b0, 0, 2, -1);
    run_instr(6'b100000, 6'h00, 1'b0, 0, 3, -1);

    bus.decrypt_done = 2'b11;
    drain(1'b1);
    bus.decrypt_done = 2'b01;
    drain(1'b1);
    reset_mid_exec();
    bus.decrypt_done = 2'b11;
    drain(1'b0);
    run_instr(6'b000010, 6'h0F, 1'b0, 0, 2, 1);
    drain(1'b0);

    for (int t = 0; t < 40; t++) begin
      op = OP_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0: op[3:0] = 4'h1;
          1: op[3:0] = 4'hA;
          2: op[3:0] = 4'hC;
          3: op[3:0] = 4'hD;
          4: op[3:0] = 4'hE;
          default: op[3:0] = 4'hF;
        endcase
      end
      fn = FUNC_W'($urandom);
      d  = $urandom_range(0, 4);
      h  = $urandom_range(2, 5);
      rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_RD_CH - 1)) : -1;
      run_instr(op, fn, 1'($urandom_range(0, 1)), d, h, rc);
      if (rc >= 0) drain(1'b0);
      if ($urandom_range(0, 3) == 0) begin
        bus.decrypt_done = NUM_RD_CH'($urandom_range(1, (1 << NUM_RD_CH) - 1));
        drain(1'($urandom_range(0, 1)));
      end
    end

`ifdef INSTR_SEQ_FLUSH_TIMEOUT_EN
    run_instr(6'b100000, 6'h00, 1'b0, -1, 0, -1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rr_ptr = 0;
    @(negedge clk);
    chk("flush_err_cleared", 64'(bus.flush_err), 64'(0));
    $display("flush timeout then reset");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
